// File: rtl/is_uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART controller slice (package is_pkg_uart_controller).
// Holds the TX arbiter state encoding and the default tag byte base.
package is_pkg_uart_controller;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_TAG,
    ARB_STREAM
  } arb_state_t;

  localparam logic [7:0] ARB_TAG_BASE_DEF = 8'hA0;

endpackage

// File: rtl/is_rr_arbiter.sv
// Round-robin pointer and registered one-hot grant for the UART TX arbiter.
// load_i latches the winner searched from ptr; advance_i ends the grant and rotates ptr past it.
module is_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     load_i,
  input  logic                     advance_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  int               cand;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else if (advance_i) begin
      grant_q <= '0;
      ptr_q   <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    end else if (load_i && win_found) begin
      grant_q <= N_REQ'(1) << win_idx;
      idx_q   <= win_idx;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;

endmodule

// File: rtl/is_uart_tx_arbiter.sv
// Burst-granular round-robin arbiter sharing the UART TX byte interface between N_REQ streams.
// Define IS_UART_ARB_TAG_EN to prefix every grant with one tag byte (TAG_BASE | index).
module is_uart_tx_arbiter
  import is_pkg_uart_controller::*;
#(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
`ifdef IS_UART_ARB_TAG_EN
  ,
  parameter logic [DATA_W-1:0] TAG_BASE = DATA_W'(ARB_TAG_BASE_DEF)
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] grant_idx;
  logic             arb_load;
  logic             arb_advance;
  logic             beat;

  is_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_valid_i),
    .load_i      (arb_load),
    .advance_i   (arb_advance),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Outputs are forced idle while reset is asserted, even if the state register still shows a burst.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    arb_load    = 1'b0;
    arb_advance = 1'b0;
    beat        = 1'b0;
    busy_o      = 1'b0;
    if (!rst_i) begin
      busy_o = (state_q != ARB_IDLE);
      case (state_q)
        ARB_IDLE: begin
          arb_load = 1'b1;
          if (|req_valid_i) begin
`ifdef IS_UART_ARB_TAG_EN
            state_d = ARB_TAG;
`else
            state_d = ARB_STREAM;
`endif
          end
        end
`ifdef IS_UART_ARB_TAG_EN
        ARB_TAG: begin
          tx_valid_o = 1'b1;
          tx_data_o  = TAG_BASE | DATA_W'(grant_idx);
          if (tx_ready_i) state_d = ARB_STREAM;
        end
`endif
        ARB_STREAM: begin
          tx_valid_o             = req_valid_i[grant_idx];
          req_ready_o[grant_idx] = tx_ready_i;
          if (req_valid_i[grant_idx]) tx_data_o = req_data_i[grant_idx*DATA_W +: DATA_W];
          beat = req_valid_i[grant_idx] & tx_ready_i;
          if (beat) begin
            // A last beat that also hits the limit is still one burst end.
            if (req_last_i[grant_idx] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
              state_d     = ARB_IDLE;
              beat_cnt_d  = '0;
              arb_advance = 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

endmodule
